// File: rtl/krnl_vadd_rtl_pkg.sv
// Shared types and helpers for the vadd RTL kernel control path.
//   state_e          : start-sequencer FSM states
//   beat_bytes_log2  : log2 of bytes per memory beat for a given data width
package krnl_vadd_rtl_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Legal widths are 32..512; anything else falls back to 512-bit beats.
  function automatic int unsigned beat_bytes_log2(input int unsigned data_width);
    int unsigned r;
    case (data_width)
      32:      r = 2;
      64:      r = 3;
      128:     r = 4;
      256:     r = 5;
      default: r = 6;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/krnl_vadd_rtl_done_tracker.sv
// Sticky completion flags for the read and write masters.
//   aclk, areset      : clock, synchronous active-high reset
//   clear_i           : clears both flags (job launch)
//   enable_i          : done pulses are only accepted while high
//   rd_done_i/wr_done_i : single-cycle completion pulses
//   both_done_c_o     : both masters finished, including a pulse this cycle
module krnl_vadd_rtl_done_tracker (
  input  logic aclk,
  input  logic areset,
  input  logic clear_i,
  input  logic enable_i,
  input  logic rd_done_i,
  input  logic wr_done_i,
  output logic both_done_c_o
);

  logic rd_seen_q, rd_seen_d;
  logic wr_seen_q, wr_seen_d;
  logic rd_hit_c, wr_hit_c;

  assign rd_hit_c = enable_i & rd_done_i;
  assign wr_hit_c = enable_i & wr_done_i;

  // Next flag values: clear wins, otherwise set-and-hold.
  always_comb begin
    rd_seen_d = rd_seen_q;
    wr_seen_d = wr_seen_q;
    if (clear_i) begin
      rd_seen_d = 1'b0;
      wr_seen_d = 1'b0;
    end else begin
      if (rd_hit_c) rd_seen_d = 1'b1;
      if (wr_hit_c) wr_seen_d = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_seen_q <= 1'b0;
      wr_seen_q <= 1'b0;
    end else begin
      rd_seen_q <= rd_seen_d;
      wr_seen_q <= wr_seen_d;
    end
  end

  // Bypass the live pulses so the FSM can leave RUN in the cycle the last one arrives.
  assign both_done_c_o = (rd_seen_q | rd_hit_c) & (wr_seen_q | wr_hit_c);

endmodule

// File: rtl/krnl_vadd_rtl_start_seq.sv
// Start sequencer for the vadd kernel: turns an ap_start level into one
// launch of the read and write masters and one ap_done pulse.
//   aclk, areset              : clock, synchronous active-high reset
//   ap_start/ap_idle/ap_done  : control-block handshake
//   size_in_bytes             : job size; zero completes without a launch
//   axi00_ptr0/axi00_ptr1     : source / destination byte addresses
//   rd_start/wr_start         : one-cycle launch pulses
//   rd_addr/wr_addr           : latched launch addresses
//   rd_xfer_len/wr_xfer_len   : latched beat counts
//   rd_done/wr_done           : master completion pulses
//   cycle_count               : busy-cycle counter, only with KRNL_VADD_PERF_CNT_EN
module krnl_vadd_rtl_start_seq
  import krnl_vadd_rtl_pkg::*;
#(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
  parameter int unsigned C_XFER_LEN_WIDTH   = 32
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        ap_start,
  output logic                        ap_idle,
  output logic                        ap_done,
  input  logic [31:0]                 size_in_bytes,
  input  logic [63:0]                 axi00_ptr0,
  input  logic [63:0]                 axi00_ptr1,
  output logic                        rd_start,
  output logic                        wr_start,
  output logic [63:0]                 rd_addr,
  output logic [63:0]                 wr_addr,
  output logic [C_XFER_LEN_WIDTH-1:0] rd_xfer_len,
  output logic [C_XFER_LEN_WIDTH-1:0] wr_xfer_len,
  input  logic                        rd_done,
  input  logic                        wr_done
`ifdef KRNL_VADD_PERF_CNT_EN
  ,
  output logic [63:0]                 cycle_count
`endif
);

  localparam int unsigned BEAT_SHIFT = beat_bytes_log2(C_M_AXI_DATA_WIDTH);
  localparam logic [31:0] LOW_MASK   = 32'((33'd1 << BEAT_SHIFT) - 33'd1);

  state_e                      state_q, state_d;
  logic                        ap_start_q;
  logic                        ap_idle_q, ap_done_q, start_q;
  logic [63:0]                 rd_addr_q, wr_addr_q;
  logic [C_XFER_LEN_WIDTH-1:0] xfer_len_q;
  logic                        start_edge_c, launch_c, zero_job_c, both_done_c;
  logic [31:0]                 beats_c;
  logic [C_XFER_LEN_WIDTH-1:0] xfer_len_c;

  // Beat count: shift out the in-beat bytes, add one if any were left over.
  assign beats_c    = (size_in_bytes >> BEAT_SHIFT) + 32'(|(size_in_bytes & LOW_MASK));
  assign xfer_len_c = C_XFER_LEN_WIDTH'(beats_c);

  assign start_edge_c = ap_start & ~ap_start_q & (state_q == ST_IDLE);

  krnl_vadd_rtl_done_tracker u_done_tracker (
    .aclk          (aclk),
    .areset        (areset),
    .clear_i       (launch_c),
    .enable_i      ((state_q == ST_LAUNCH) || (state_q == ST_RUN)),
    .rd_done_i     (rd_done),
    .wr_done_i     (wr_done),
    .both_done_c_o (both_done_c)
  );

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    launch_c   = 1'b0;
    zero_job_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge_c) begin
          if (size_in_bytes != 32'd0) begin
            state_d  = ST_LAUNCH;
            launch_c = 1'b1;
          end else begin
            state_d    = ST_DONE;
            zero_job_c = 1'b1;
          end
        end
      end
      ST_LAUNCH: state_d = ST_RUN;
      ST_RUN:    if (both_done_c) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Registered handshake outputs and launch payload.
  always_ff @(posedge aclk) begin
    if (areset) begin
      ap_start_q <= 1'b0;
      ap_idle_q  <= 1'b1;
      ap_done_q  <= 1'b0;
      start_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      xfer_len_q <= '0;
    end else begin
      ap_start_q <= ap_start;
      // Idle stays low through the cycle after DONE so the busy window always spans the ap_done pulse edge.
      ap_idle_q  <= (state_d == ST_IDLE) && (state_q != ST_DONE);
      ap_done_q  <= (state_d == ST_DONE);
      start_q    <= launch_c;
      if (launch_c) begin
        rd_addr_q  <= axi00_ptr0;
        wr_addr_q  <= axi00_ptr1;
        xfer_len_q <= xfer_len_c;
      end
    end
  end

`ifdef KRNL_VADD_PERF_CNT_EN
  logic [63:0] cycle_count_q;

  // Busy-cycle counter; holds its value after the job so software can read it.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cycle_count_q <= '0;
    end else if (launch_c || zero_job_c) begin
      cycle_count_q <= '0;
    end else if ((state_q == ST_LAUNCH) || (state_q == ST_RUN)) begin
      cycle_count_q <= cycle_count_q + 64'd1;
    end
  end

  assign cycle_count = cycle_count_q;
`endif

  assign ap_idle     = ap_idle_q;
  assign ap_done     = ap_done_q;
  assign rd_start    = start_q;
  assign wr_start    = start_q;
  assign rd_addr     = rd_addr_q;
  assign wr_addr     = wr_addr_q;
  assign rd_xfer_len = xfer_len_q;
  assign wr_xfer_len = xfer_len_q;

endmodule
